// File: rtl/usb_ep0_setup_responder_if.sv
// EP0 receive beats (tokens and setup data) and transmit response bytes.
interface usb_ep0_setup_responder_if;
   logic        rx_pkt_valid;
   logic [3:0]  rx_pid;
   logic [6:0]  rx_addr;
   logic [3:0]  rx_ep;
   logic [7:0]  rx_data;
   logic        rx_data_valid;
   logic        rx_crc_err;
   logic        tx_valid;
   logic [3:0]  tx_pid;
   logic [7:0]  tx_data;
   logic [15:0] tx_len;

   modport master (
      output rx_pkt_valid, rx_pid, rx_addr, rx_ep, rx_data, rx_data_valid, rx_crc_err,
      input  tx_valid, tx_pid, tx_data, tx_len
   );

   modport slave (
      input  rx_pkt_valid, rx_pid, rx_addr, rx_ep, rx_data, rx_data_valid, rx_crc_err,
      output tx_valid, tx_pid, tx_data, tx_len
   );
endinterface

// File: rtl/usb_ep0_setup_responder.sv
// EP0 SETUP capture/decode; answers GET_DESCRIPTOR(Device), SET_ADDRESS or STALL.
// First tx beat 2 clocks after the 8th setup byte; no backpressure, one byte per cycle.
module usb_ep0_setup_responder #(
   parameter int unsigned DESC_LEN = 18,
   parameter logic [15:0] VID      = 16'h1234,
   parameter logic [15:0] PID_PROD = 16'h5678
) (
   input  logic                       clk,
   input  logic                       rst_n,
   usb_ep0_setup_responder_if.slave   ep0,
   output logic [6:0]                 dev_addr,
   output logic                       busy
);
   localparam logic [3:0] PID_SETUP = 4'hD;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_STALL = 4'hE;

   typedef enum logic [2:0] {
      IDLE, SETUP_RX, DECODE, DATA_TX, STATUS_TX, ADDR_UPD, STALL_TX
   } state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [4:0]  idx;
   logic [15:0] len_q;
   logic [6:0]  pending_addr;
   logic [7:0]  setup [8];
   logic        tx_vld_q;
   logic [3:0]  tx_pid_q;
   logic [7:0]  tx_dat_q;
   logic [15:0] tx_len_q;

   logic        tok_ok;
   logic        is_get_desc;
   logic        is_set_addr;
   logic [15:0] w_length;
   logic [15:0] clamp_len;
   logic        last_beat;

   function automatic logic [7:0] desc_byte(input logic [4:0] i);
      case (i)
         5'd0:  desc_byte = 8'h12;
         5'd1:  desc_byte = 8'h01;
         5'd2:  desc_byte = 8'h10;
         5'd3:  desc_byte = 8'h01;
         5'd7:  desc_byte = 8'h40;
         5'd8:  desc_byte = VID[7:0];
         5'd9:  desc_byte = VID[15:8];
         5'd10: desc_byte = PID_PROD[7:0];
         5'd11: desc_byte = PID_PROD[15:8];
         5'd13: desc_byte = 8'h01;
         5'd14: desc_byte = 8'h01;
         5'd15: desc_byte = 8'h02;
         5'd16: desc_byte = 8'h03;
         5'd17: desc_byte = 8'h01;
         default: desc_byte = 8'h00;
      endcase
   endfunction

   assign tok_ok = ep0.rx_pkt_valid && !ep0.rx_data_valid && (ep0.rx_pid == PID_SETUP)
                   && (ep0.rx_ep == 4'd0) && (ep0.rx_addr == dev_addr);

   assign is_get_desc = (setup[0] == 8'h80) && (setup[1] == 8'h06) && (setup[3] == 8'h01);
   assign is_set_addr = (setup[0] == 8'h00) && (setup[1] == 8'h05);
   assign w_length    = {setup[7], setup[6]};
   assign clamp_len   = (w_length < 16'(DESC_LEN)) ? w_length : 16'(DESC_LEN);
   // A zero-length reply still occupies one beat, hence "<=" rather than "==".
   assign last_beat   = (len_q <= ({11'd0, idx} + 16'd1));

   // A new SETUP collides with any response in flight, so it kills tx immediately.
   assign ep0.tx_valid = tx_vld_q && !tok_ok;
   assign ep0.tx_pid   = tok_ok ? 4'd0  : tx_pid_q;
   assign ep0.tx_data  = tok_ok ? 8'd0  : tx_dat_q;
   assign ep0.tx_len   = tok_ok ? 16'd0 : tx_len_q;
   assign busy         = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         len_q        <= '0;
         pending_addr <= '0;
         dev_addr     <= '0;
         tx_vld_q     <= 1'b0;
         tx_pid_q     <= '0;
         tx_dat_q     <= '0;
         tx_len_q     <= '0;
         for (int i = 0; i < 8; i++) setup[i] <= '0;
      end else begin
         tx_vld_q <= 1'b0;
         tx_pid_q <= '0;
         tx_dat_q <= '0;
         tx_len_q <= '0;
         if (tok_ok) begin
            state        <= SETUP_RX;
            cnt          <= '0;
            pending_addr <= '0;
         end else begin
            case (state)
               IDLE: ;
               SETUP_RX: begin
                  if (ep0.rx_pkt_valid && ep0.rx_crc_err) begin
                     state <= IDLE;
                  end else if (ep0.rx_pkt_valid && ep0.rx_data_valid) begin
                     setup[cnt] <= ep0.rx_data;
                     cnt        <= cnt + 3'd1;
                     if (cnt == 3'd7) state <= DECODE;
                  end
               end
               DECODE: begin
                  idx <= '0;
                  if (is_get_desc) begin
                     len_q <= clamp_len;
                     state <= DATA_TX;
                  end else if (is_set_addr) begin
                     pending_addr <= setup[2][6:0];
                     state        <= STATUS_TX;
                  end else begin
                     state <= STALL_TX;
                  end
               end
               DATA_TX: begin
                  tx_vld_q <= 1'b1;
                  tx_pid_q <= PID_DATA1;
                  tx_len_q <= len_q;
                  tx_dat_q <= (len_q == 16'd0) ? 8'h00 : desc_byte(idx);
                  idx      <= idx + 5'd1;
                  if (last_beat) state <= IDLE;
               end
               STATUS_TX: begin
                  tx_vld_q <= 1'b1;
                  tx_pid_q <= PID_DATA1;
                  state    <= ADDR_UPD;
               end
               ADDR_UPD: begin
                  dev_addr <= pending_addr;
                  state    <= IDLE;
               end
               STALL_TX: begin
                  tx_vld_q <= 1'b1;
                  tx_pid_q <= PID_STALL;
                  state    <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
